// File: rtl/intt_pkg.sv
// Shared definitions for the inverse-NTT layer controller and its butterfly.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package intt_pkg;

    // Layer controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } intt_state_e;

    localparam int INTT_DATA_W     = 30;
    localparam int INTT_IDX_W      = 32;
    localparam int INTT_BF_LATENCY = 6;

    // Coefficient modulus selected by MOD_INDEX; every entry is below 2^30.
    function automatic logic [INTT_DATA_W-1:0] intt_modulus(input int idx);
        case (idx)
            1:       return 30'd1071644673;
            default: return 30'd1073479681;
        endcase
    endfunction

    // Twiddle index for group g of layer s: (N >> (s+1)) + g, evaluated at INTT_IDX_W bits.
    function automatic logic [INTT_IDX_W-1:0] intt_tw_index(input int unsigned log_n,
                                                            input int unsigned s,
                                                            input int unsigned g);
        return ((INTT_IDX_W'(1) << log_n) >> (s + 1)) + INTT_IDX_W'(g);
    endfunction

endpackage

// File: rtl/intt_stage_ctrl_bf.sv
// Gentleman-Sande butterfly: sum = a+b mod q, dif = (a-b)*w mod q.
// Latency: LATENCY cycles from operands to results (LATENCY >= 2), fully pipelined.
// Backpressure: none; accepts one operand set per cycle, datapath is not reset.
module gs_butterfly
    import intt_pkg::*;
#(
    parameter int MOD_INDEX = 0,
    parameter int LATENCY   = INTT_BF_LATENCY
) (
    input  logic                   clk_i,
    input  logic [INTT_DATA_W-1:0] a_i,
    input  logic [INTT_DATA_W-1:0] b_i,
    input  logic [INTT_DATA_W-1:0] w_i,
    output logic [INTT_DATA_W-1:0] sum_o,
    output logic [INTT_DATA_W-1:0] dif_o
);

    localparam logic [INTT_DATA_W-1:0] Q = intt_modulus(MOD_INDEX);

    logic [INTT_DATA_W:0]     sum_w;
    logic [INTT_DATA_W-1:0]   sum_red_w;
    logic [INTT_DATA_W-1:0]   dif_w;
    logic [INTT_DATA_W-1:0]   s1_sum_q;
    logic [2*INTT_DATA_W-1:0] s1_prod_q;
    logic [INTT_DATA_W-1:0]   sum_pipe_q [LATENCY-1];
    logic [INTT_DATA_W-1:0]   dif_pipe_q [LATENCY-1];

    // Modular add and subtract on operands already reduced below q.
    always_comb begin
        sum_w     = {1'b0, a_i} + {1'b0, b_i};
        sum_red_w = INTT_DATA_W'((sum_w >= {1'b0, Q}) ? (sum_w - {1'b0, Q}) : sum_w);
        dif_w     = (a_i >= b_i) ? (a_i - b_i) : (a_i + (Q - b_i));
    end

    // Stage 1 multiplies, stage 2 reduces, remaining stages only delay to the target latency.
    always_ff @(posedge clk_i) begin
        s1_sum_q      <= sum_red_w;
        s1_prod_q     <= {{INTT_DATA_W{1'b0}}, dif_w} * {{INTT_DATA_W{1'b0}}, w_i};
        sum_pipe_q[0] <= s1_sum_q;
        dif_pipe_q[0] <= INTT_DATA_W'(s1_prod_q % {{INTT_DATA_W{1'b0}}, Q});
        for (int i = 1; i < LATENCY - 1; i++) begin
            sum_pipe_q[i] <= sum_pipe_q[i-1];
            dif_pipe_q[i] <= dif_pipe_q[i-1];
        end
    end

    assign sum_o = sum_pipe_q[LATENCY-2];
    assign dif_o = dif_pipe_q[LATENCY-2];

endmodule

// File: rtl/intt_stage_ctrl.sv
// Runs one inverse-NTT layer: issues N/2 butterfly read pairs, writes results back.
// Latency: reads in cycles 1..N/2 after start, writes BF_LATENCY+1 cycles after each read, done after last write.
// Backpressure: none; start is ignored while busy (including the done cycle).
module intt_stage_ctrl
    import intt_pkg::*;
#(
    parameter int  MOD_INDEX  = 0,
    parameter int  LOG_N      = 10,
    parameter int  BF_LATENCY = INTT_BF_LATENCY,
    localparam int STAGE_W    = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [STAGE_W-1:0]     stage,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [LOG_N-1:0]       rd_addr_a,
    output logic [LOG_N-1:0]       rd_addr_b,
    output logic [LOG_N-1:0]       tw_addr,
    input  logic [INTT_DATA_W-1:0] rd_data_a,
    input  logic [INTT_DATA_W-1:0] rd_data_b,
    input  logic [INTT_DATA_W-1:0] tw_data,
    output logic                   wr_en,
    output logic [LOG_N-1:0]       wr_addr_a,
    output logic [LOG_N-1:0]       wr_addr_b,
    output logic [INTT_DATA_W-1:0] wr_data_a,
    output logic [INTT_DATA_W-1:0] wr_data_b
);

    localparam logic [LOG_N-1:0] LAST_K = LOG_N'((64'd1 << (LOG_N - 1)) - 64'd1);

    intt_state_e          state_q, state_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [LOG_N-1:0]     k_q, k_d;
    logic [BF_LATENCY:0]  vld_q;
    logic [LOG_N-1:0]     pa_q [BF_LATENCY+1];
    logic [LOG_N-1:0]     pb_q [BF_LATENCY+1];
    logic [LOG_N-1:0]     t_w, g_w, j_w, a_w, tw_w;

    // Next state, stage latch and pair counter; start only counts in IDLE.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        rd_en   = 1'b0;
        done    = 1'b0;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stage_d = stage;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rd_en = 1'b1;
                k_d   = k_q + LOG_N'(1);
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last write is on the bus when nothing else is behind it in the pipe.
                if (vld_q[BF_LATENCY] && (vld_q[BF_LATENCY-1:0] == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pair k -> group g, offset j; addresses are forced to zero whenever no read is issued.
    always_comb begin
        t_w       = LOG_N'(1) << stage_q;
        g_w       = k_q >> stage_q;
        j_w       = k_q & (t_w - LOG_N'(1));
        a_w       = ((g_w << 1) << stage_q) | j_w;
        tw_w      = LOG_N'(intt_tw_index(LOG_N, 32'(stage_q), 32'(g_w)));
        rd_addr_a = rd_en ? a_w : '0;
        rd_addr_b = rd_en ? (a_w + t_w) : '0;
        tw_addr   = rd_en ? tw_w : '0;
    end

    // Control state plus the valid/address pipe that tracks each pair to its write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            k_q     <= '0;
            vld_q   <= '0;
            for (int i = 0; i <= BF_LATENCY; i++) begin
                pa_q[i] <= '0;
                pb_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            vld_q   <= {vld_q[BF_LATENCY-1:0], rd_en};
            pa_q[0] <= rd_addr_a;
            pb_q[0] <= rd_addr_b;
            for (int i = 1; i <= BF_LATENCY; i++) begin
                pa_q[i] <= pa_q[i-1];
                pb_q[i] <= pb_q[i-1];
            end
        end
    end

    assign wr_en     = vld_q[BF_LATENCY];
    assign wr_addr_a = wr_en ? pa_q[BF_LATENCY] : '0;
    assign wr_addr_b = wr_en ? pb_q[BF_LATENCY] : '0;

    gs_butterfly #(
        .MOD_INDEX (MOD_INDEX),
        .LATENCY   (BF_LATENCY)
    ) u_bf (
        .clk_i (clk),
        .a_i   (rd_data_a),
        .b_i   (rd_data_b),
        .w_i   (tw_data),
        .sum_o (wr_data_a),
        .dif_o (wr_data_b)
    );

endmodule

// File: tb/tb_intt_stage_ctrl.sv
// Bench for intt_stage_ctrl at LOG_N=3: random coefficient memory, reference layer model.
// Latency: checks read/write/done cycle positions relative to the accepted start.
// Backpressure: none modelled; memory answers every read one cycle later.
module tb_intt_stage_ctrl;

    localparam int LOG_N = 3;
    localparam int N     = 8;
    localparam int HALF  = 4;
    localparam int L     = 6;
    localparam longint unsigned Q = 64'd1073479681;

    typedef struct {
        int              rel;
        int              a;
        int              b;
        int              tw;
        longint unsigned da;
        longint unsigned db;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  stage = '0;
    logic        busy, done, rd_en, wr_en;
    logic [2:0]  rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;
    logic [29:0] rd_data_a, rd_data_b, tw_data, wr_data_a, wr_data_b;

    logic [29:0] mem    [N];
    logic [29:0] tw_rom [N];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    intt_stage_ctrl #(.MOD_INDEX(0), .LOG_N(LOG_N), .BF_LATENCY(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stage     (stage),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .tw_data   (tw_data),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .wr_data_a (wr_data_a),
        .wr_data_b (wr_data_b)
    );

    // Synchronous-read coefficient RAM and twiddle ROM.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
            tw_data   <= tw_rom[tw_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one layer at the current negedge, log the bus until done, compare with the model.
    task automatic run_layer(input int s, input bit dup, input bit directed);
        ev_t rd_log[$];
        ev_t wr_log[$];
        int  rel, done_rel, busy_first, busy_last, busy_cnt, idx, t, ngrp;
        longint unsigned av, bv, wv, ea, eb;
        for (int i = 0; i < N; i++) begin
            mem[i]    = 30'($urandom_range(32'd1073479680, 32'd0));
            tw_rom[i] = 30'($urandom_range(32'd1073479680, 32'd0));
        end
        if (directed) begin
            mem[0]    = 30'd5;
            mem[1]    = 30'd3;
            tw_rom[4] = 30'd1;
        end
        stage = 2'(s);
        start = 1'b1;
        rel = 0; done_rel = 0; busy_first = 0; busy_last = 0; busy_cnt = 0;
        while (done_rel == 0 && rel < 64) begin
            @(negedge clk);
            rel++;
            if (rd_en) rd_log.push_back('{rel, int'(rd_addr_a), int'(rd_addr_b), int'(tw_addr), 0, 0});
            if (wr_en) wr_log.push_back('{rel, int'(wr_addr_a), int'(wr_addr_b), 0,
                                          longint'(wr_data_a), longint'(wr_data_b)});
            if (busy) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = rel;
                busy_last = rel;
            end
            if (done) done_rel = rel;
            if (rel == 1) start = 1'b0;
            if (dup && rel == 3) begin
                start = 1'b1;
                stage = 2'((s + 1) % LOG_N);
            end
            if (dup && rel == 4) start = 1'b0;
        end
        check("done_cycle", done_rel, HALF + L + 2);
        check("busy_first", busy_first, 1);
        check("busy_last", busy_last, HALF + L + 2);
        check("busy_cycles", busy_cnt, HALF + L + 2);
        check("rd_count", rd_log.size(), HALF);
        check("wr_count", wr_log.size(), HALF);
        t = 1 << s;
        ngrp = N / (2 * t);
        idx = 0;
        for (int g = 0; g < ngrp; g++) begin
            for (int j = 0; j < t; j++) begin
                int a, b, tw;
                a  = g * 2 * t + j;
                b  = a + t;
                tw = ngrp + g;
                av = longint'(mem[a]);
                bv = longint'(mem[b]);
                wv = longint'(tw_rom[tw]);
                ea = (av + bv) % Q;
                eb = (((av + Q - bv) % Q) * wv) % Q;
                if (idx < rd_log.size()) begin
                    check($sformatf("s%0d_rd%0d_cycle", s, idx), rd_log[idx].rel, 1 + idx);
                    check($sformatf("s%0d_rd%0d_addr_a", s, idx), rd_log[idx].a, a);
                    check($sformatf("s%0d_rd%0d_addr_b", s, idx), rd_log[idx].b, b);
                    check($sformatf("s%0d_rd%0d_tw", s, idx), rd_log[idx].tw, tw);
                end
                if (idx < wr_log.size()) begin
                    check($sformatf("s%0d_wr%0d_cycle", s, idx), wr_log[idx].rel, 2 + idx + L);
                    check($sformatf("s%0d_wr%0d_addr_a", s, idx), wr_log[idx].a, a);
                    check($sformatf("s%0d_wr%0d_addr_b", s, idx), wr_log[idx].b, b);
                    check($sformatf("s%0d_wr%0d_data_a", s, idx), wr_log[idx].da, ea);
                    check($sformatf("s%0d_wr%0d_data_b", s, idx), wr_log[idx].db, eb);
                end
                idx++;
            end
        end
        if (directed && wr_log.size() > 0) begin
            check("dir_wr_addr_a", wr_log[0].a, 0);
            check("dir_wr_addr_b", wr_log[0].b, 1);
            check("dir_sum", wr_log[0].da, 8);
            check("dir_dif", wr_log[0].db, 2);
        end
    endtask

    initial begin
        int wr_seen, done_seen;
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_addr_a", rd_addr_a, 0);
        check("rst_rd_addr_b", rd_addr_b, 0);
        check("rst_tw_addr", tw_addr, 0);
        check("rst_wr_addr_a", wr_addr_a, 0);
        check("rst_wr_addr_b", wr_addr_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // Layer 0 with a known butterfly on pair 0, then layer 2.
        run_layer(0, 1'b0, 1'b1);
        @(negedge clk);
        run_layer(2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Second start in cycle 3 with a different stage must be ignored.
        run_layer(int'($urandom_range(2, 0)), 1'b1, 1'b0);
        @(negedge clk);

        // Reset in cycle 5 aborts the layer with no further writes.
        stage = 2'd1;
        start = 1'b1;
        for (int rel = 1; rel <= 5; rel++) begin
            @(negedge clk);
            if (rel == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rd_en", rd_en, 0);
        wr_seen = 0;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_en) wr_seen++;
            if (done) done_seen++;
        end
        check("abort_no_wr", wr_seen, 0);
        check("abort_no_done", done_seen, 0);
        run_layer(1, 1'b0, 1'b0);

        // Start coincident with done is dropped; start one cycle later is accepted.
        start = 1'b1;
        stage = 2'd0;
        @(negedge clk);
        run_layer(2, 1'b0, 1'b0);

        // A few random layers with random idle gaps.
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(3, 1)) @(negedge clk);
            run_layer(int'($urandom_range(2, 0)), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
